// File: rtl/ucore_cfg_loader.sv
// Configuration sequencer for a ucore cfg chain: loads the inactive cache entry word by word,
// then issues a switch pulse once the fabric is idle. Optional feature macro: CFG_LOADER_PARITY_EN.
module ucore_cfg_loader #(
   parameter int CFG_WIDTH     = 64,
   parameter int NUM_UCORES    = 16,
   parameter int CACHE_ENTRIES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [1:0]           start_entry,
   input  logic                 abort,
   input  logic                 word_valid,
   input  logic [CFG_WIDTH-1:0] word_data,
`ifdef CFG_LOADER_PARITY_EN
   input  logic                 word_parity,
`endif
   output logic                 word_ready,
   input  logic                 fabric_idle,
   output logic                 chain_en,
   output logic [CFG_WIDTH-1:0] chain_data,
   output logic                 cfg_switch,
   output logic [1:0]           switch_entry,
   output logic [1:0]           active_entry,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   localparam int CW = $clog2(NUM_UCORES + 1);
   localparam logic [2:0]    ENTRY_LIMIT = 3'(CACHE_ENTRIES);
   localparam logic [CW-1:0] LAST_IDX    = CW'(NUM_UCORES - 1);
   localparam logic [CW-1:0] FULL_COUNT  = CW'(NUM_UCORES);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_IDLE, SWITCH} state_t;

   state_t          state, state_nx;
   logic [1:0]      tgt;
   logic [CW-1:0]   count;
   logic            accept;
   logic            word_ok;
   logic            start_ok;
   logic            start_bad;

   // A word is accepted whenever LOAD sees word_valid; word_ready depends on state alone.
   always_comb begin
      word_ready = (state == LOAD);
      accept     = word_valid && word_ready;
`ifdef CFG_LOADER_PARITY_EN
      word_ok    = (word_parity == ^word_data);
`else
      word_ok    = 1'b1;
`endif
      start_ok   = start && ({1'b0, start_entry} < ENTRY_LIMIT) && (start_entry != active_entry);
      start_bad  = start && !start_ok;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      if (start_ok) state_nx = LOAD;
         LOAD: begin
            // abort and a parity failure both outrank the last-word transition
            if (abort || (accept && !word_ok))       state_nx = IDLE;
            else if (accept && (count == LAST_IDX)) state_nx = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (abort)            state_nx = IDLE;
            else if (fabric_idle) state_nx = SWITCH;
         end
         SWITCH:    state_nx = IDLE;
         default:   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         tgt          <= 2'd0;
         count        <= '0;
         active_entry <= 2'd0;
         chain_en     <= 1'b0;
         chain_data   <= '0;
         err          <= 1'b0;
      end else begin
         state    <= state_nx;
         chain_en <= accept && word_ok;
         err      <= ((state == IDLE) && start_bad) || (accept && !word_ok);
         if (accept && word_ok)
            chain_data <= {tgt, word_data[CFG_WIDTH-3:0]};
         if ((state == IDLE) && start_ok) begin
            tgt   <= start_entry;
            count <= '0;
         end else if (accept && (count != FULL_COUNT)) begin
            count <= count + 1'b1;
         end
         if (state == SWITCH)
            active_entry <= tgt;
      end
   end

   always_comb begin
      cfg_switch   = (state == SWITCH);
      done         = (state == SWITCH);
      switch_entry = (state == SWITCH) ? tgt : 2'd0;
      busy         = (state != IDLE);
   end

endmodule

// File: tb/tb_ucore_cfg_loader.sv
// Directed bench for ucore_cfg_loader with NUM_UCORES=4, CACHE_ENTRIES=2, CFG_WIDTH=64.
module tb_ucore_cfg_loader;

   logic        clk = 1'b0;
   logic        reset, start, abort, word_valid, fabric_idle;
   logic [1:0]  start_entry;
   logic [63:0] word_data;
   logic        word_ready, chain_en, cfg_switch, busy, done, err;
   logic [63:0] chain_data;
   logic [1:0]  switch_entry, active_entry;
`ifdef CFG_LOADER_PARITY_EN
   logic        word_parity;
   logic        parity_flip = 1'b0;
   assign word_parity = (^word_data) ^ parity_flip;
`endif

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [63:0] mon_q[$];

   ucore_cfg_loader #(.CFG_WIDTH(64), .NUM_UCORES(4), .CACHE_ENTRIES(2)) dut (
      .clk(clk), .reset(reset), .start(start), .start_entry(start_entry), .abort(abort),
      .word_valid(word_valid), .word_data(word_data),
`ifdef CFG_LOADER_PARITY_EN
      .word_parity(word_parity),
`endif
      .word_ready(word_ready), .fabric_idle(fabric_idle), .chain_en(chain_en),
      .chain_data(chain_data), .cfg_switch(cfg_switch), .switch_entry(switch_entry),
      .active_entry(active_entry), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Records every word forwarded down the chain and every done pulse.
   always @(negedge clk) begin
      if (!reset && chain_en) mon_q.push_back(chain_data);
      if (!reset && done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] stamp(input logic [1:0] e, input logic [63:0] v);
      return {e, v[61:0]};
   endfunction

   task automatic chk_mon(input string tag, input logic [1:0] e, input int first);
      chk({tag, "_count"}, 64'(mon_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < mon_q.size(); i++)
         chk({tag, "_word"}, mon_q[i], stamp(e, 64'(first + i)));
   endtask

   initial begin
      int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      int d;
      reset = 1'b1; start = 1'b0; start_entry = 2'd0; abort = 1'b0;
      word_valid = 1'b0; word_data = 64'd0; fabric_idle = 1'b1;
      tick(); tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_active", 64'(active_entry), 64'd0);
      chk("rst_chain_en", 64'(chain_en), 64'd0);
      chk("rst_chain_data", chain_data, 64'd0);
      chk("rst_ready", 64'(word_ready), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_switch", 64'({cfg_switch, done, switch_entry}), 64'd0);
      reset = 1'b0;
      tick();

      // Basic load into entry 1, back-to-back words, fabric idle
      start = 1'b1; start_entry = 2'd1;
      tick();
      start = 1'b0;
      chk("t1_busy", 64'(busy), 64'd1);
      chk("t1_ready", 64'(word_ready), 64'd1);
      chk("t1_no_en_yet", 64'(chain_en), 64'd0);
      mon_q.delete();
      for (int i = 1; i <= 4; i++) begin
         word_valid = 1'b1; word_data = 64'(i);
         // a start during LOAD must neither retarget nor raise err
         start = (i == 2); start_entry = 2'd0;
         tick();
         chk("t1_en", 64'(chain_en), 64'd1);
         chk("t1_data", chain_data, stamp(2'd1, 64'(i)));
         chk("t1_err", 64'(err), 64'd0);
      end
      start = 1'b0; word_valid = 1'b0;
      chk("t1_ready_wait", 64'(word_ready), 64'd0);
      tick();
      chk("t1_en_off", 64'(chain_en), 64'd0);
      chk("t1_switch", 64'({cfg_switch, done}), 64'b11);
      chk("t1_switch_entry", 64'(switch_entry), 64'd1);
      chk("t1_active_before", 64'(active_entry), 64'd0);
      tick();
      chk("t1_switch_off", 64'(cfg_switch), 64'd0);
      chk("t1_active", 64'(active_entry), 64'd1);
      chk("t1_idle", 64'(busy), 64'd0);
      chk_mon("t1_mon", 2'd1, 1);

      // Rejected starts: entry equal to active, entry beyond cache
      start = 1'b1; start_entry = 2'd1;
      tick();
      start = 1'b0;
      chk("t2_err_same", 64'(err), 64'd1);
      chk("t2_busy_same", 64'(busy), 64'd0);
      tick();
      chk("t2_err_clear", 64'(err), 64'd0);
      start = 1'b1; start_entry = 2'd2;
      tick();
      start = 1'b0;
      chk("t2_err_range", 64'(err), 64'd1);
      chk("t2_busy_range", 64'(busy), 64'd0);
      tick();

      // Gapped words into entry 0, fabric busy for 10 cycles afterwards
      fabric_idle = 1'b0;
      start = 1'b1; start_entry = 2'd0;
      tick();
      start = 1'b0;
      mon_q.delete();
      d = 5;
      for (int i = 0; i < 7; i++) begin
         word_valid = pat[i][0]; word_data = 64'(d) | 64'hC000_0000_0000_0000;
         tick();
         chk("t3_en_follows_valid", 64'(chain_en), 64'(pat[i]));
         if (pat[i] != 0) d++;
      end
      word_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t3_wait_busy", 64'(busy), 64'd1);
         chk("t3_wait_noswitch", 64'(cfg_switch), 64'd0);
      end
      chk_mon("t3_mon", 2'd0, 5);
      fabric_idle = 1'b1;
      tick();
      chk("t3_switch", 64'({cfg_switch, done}), 64'b11);
      chk("t3_switch_entry", 64'(switch_entry), 64'd0);
      tick();
      chk("t3_active", 64'(active_entry), 64'd0);
      chk("t3_done_cnt", 64'(done_cnt), 64'd2);

      // Abort after two words; the second word arrives in the abort cycle
      start = 1'b1; start_entry = 2'd1;
      tick();
      start = 1'b0;
      word_valid = 1'b1; word_data = 64'd9;
      tick();
      word_data = 64'd10; abort = 1'b1;
      tick();
      word_valid = 1'b0; abort = 1'b0;
      chk("t4_abort_idle", 64'(busy), 64'd0);
      chk("t4_abort_fwd", 64'(chain_en), 64'd1);
      chk("t4_abort_data", chain_data, stamp(2'd1, 64'd10));
      chk("t4_abort_nodone", 64'({cfg_switch, done}), 64'd0);
      tick();
      chk("t4_abort_active", 64'(active_entry), 64'd0);
      chk("t4_done_cnt", 64'(done_cnt), 64'd2);
      start = 1'b1; start_entry = 2'd1;
      tick();
      start = 1'b0;
      mon_q.delete();
      for (int i = 20; i < 24; i++) begin
         word_valid = 1'b1; word_data = 64'(i);
         tick();
      end
      word_valid = 1'b0;
      tick(); tick();
      chk("t4_reload_active", 64'(active_entry), 64'd1);
      chk_mon("t4_mon", 2'd1, 20);

      // Reset in the middle of a load
      start = 1'b1; start_entry = 2'd0;
      tick();
      start = 1'b0;
      word_valid = 1'b1; word_data = 64'd30;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; word_valid = 1'b0;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_active", 64'(active_entry), 64'd0);
      chk("t5_outputs", 64'({chain_en, cfg_switch, done, err, word_ready, switch_entry}), 64'd0);
      chk("t5_chain_data", chain_data, 64'd0);
      tick();

`ifdef CFG_LOADER_PARITY_EN
      // A bad-parity word is consumed but not forwarded, then the loader gives up
      start = 1'b1; start_entry = 2'd1;
      tick();
      start = 1'b0;
      word_valid = 1'b1; word_data = 64'd7; parity_flip = 1'b1;
      tick();
      word_valid = 1'b0; parity_flip = 1'b0;
      chk("t6_par_err", 64'(err), 64'd1);
      chk("t6_par_no_en", 64'(chain_en), 64'd0);
      chk("t6_par_idle", 64'(busy), 64'd0);
      tick();
      chk("t6_par_active", 64'(active_entry), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
